// File: rtl/data_bram_pkg.sv
// Shared types for the data BRAM arbiter: arbiter FSM states and the
// response-tracking tag carried alongside each issued BRAM command.
package data_bram_pkg;

  localparam int NUM_PORTS = 2;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic valid;
    logic port;
    logic is_read;
  } rsp_tag_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Combinational two-port grant: round-robin against the last winner,
// or only the lock owner while a lock is held.
module rr_arbiter_2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  input  logic       lock_en,
  input  logic       lock_port,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    if (lock_en) begin
      grant[lock_port] = valid[lock_port];
    end else if (&valid) begin
      // Contention: the port that did not win last time goes first.
      grant[~ptr] = 1'b1;
    end else begin
      grant = valid;
    end
  end

endmodule

// File: rtl/data_bram_arbiter.sv
// Shares the single-port data BRAM between the load/store unit (port 0) and
// the debug/DMA master (port 1); BRAM command pins come straight from flops.
module data_bram_arbiter
  import data_bram_pkg::*;
#(
  parameter  int AW = 10,
  parameter  int DW = 32,
  localparam int SW = DW / 8
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [NUM_PORTS-1:0]           i_req_valid,
  output logic [NUM_PORTS-1:0]           o_req_ready,
  input  logic [NUM_PORTS-1:0]           i_req_we,
  input  logic [NUM_PORTS-1:0]           i_req_lock,
  input  logic [NUM_PORTS-1:0][AW-1:0]   i_req_addr,
  input  logic [NUM_PORTS-1:0][SW-1:0]   i_req_strb,
  input  logic [NUM_PORTS-1:0][DW-1:0]   i_req_data,
  output logic [NUM_PORTS-1:0]           o_rsp_valid,
  output logic [DW-1:0]                  o_rsp_data,
  output logic                           o_mem_rst,
  output logic [AW-1:0]                  o_mem_addr,
  output logic                           o_mem_rden,
  output logic                           o_mem_wren,
  output logic [SW-1:0]                  o_mem_strb,
  output logic [DW-1:0]                  o_mem_data,
  input  logic [DW-1:0]                  i_mem_data,
  output arb_state_e                     o_dbg_state
);

  if (AW < 1 || (DW % 8) != 0) begin : g_bad_param
    $error("data_bram_arbiter: AW must be >= 1 and DW a multiple of 8");
  end

  // Reset to the BRAM: asserted with i_rst_n, released two edges later.
  logic [1:0] rst_sync_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rst_sync_q <= 2'b11;
    else          rst_sync_q <= {rst_sync_q[0], 1'b0};
  end

  assign o_mem_rst = rst_sync_q[1];

  // Handshake: a request on port p is accepted at a rising edge where
  // i_req_valid[p] && o_req_ready[p]; ready never waits on anything but valid
  // and arbiter state, and every accepted request gets exactly one
  // o_rsp_valid[p] pulse one cycle later with no backpressure.
  arb_state_e state_q;
  logic       lock_port_q;
  logic       ptr_q;
  logic [1:0] grant;
  logic       hs;
  logic       hs_port;

  rr_arbiter_2 u_rr_arbiter_2 (
    .valid     (i_req_valid),
    .ptr       (ptr_q),
    .lock_en   (state_q == LOCKED),
    .lock_port (lock_port_q),
    .grant     (grant)
  );

  assign o_req_ready = o_mem_rst ? '0 : grant;
  assign hs          = |o_req_ready;
  assign hs_port     = o_req_ready[1];
  assign o_dbg_state = state_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ARB;
      lock_port_q <= 1'b0;
      ptr_q       <= 1'b1;
    end else if (hs) begin
      ptr_q <= hs_port;
      // An unlocking request from the owner is still performed this cycle.
      if (i_req_lock[hs_port]) begin
        state_q     <= LOCKED;
        lock_port_q <= hs_port;
      end else begin
        state_q <= ARB;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_mem_addr <= '0;
      o_mem_rden <= 1'b0;
      o_mem_wren <= 1'b0;
      o_mem_strb <= '0;
      o_mem_data <= '0;
    end else begin
      o_mem_rden <= hs & ~i_req_we[hs_port];
      o_mem_wren <= hs &  i_req_we[hs_port];
      if (hs) begin
        o_mem_addr <= i_req_addr[hs_port];
        o_mem_strb <= i_req_strb[hs_port];
        o_mem_data <= i_req_data[hs_port];
      end
    end
  end

  // Stage 0 travels with the BRAM command; stage 1 is the visible response.
  rsp_tag_t        tag0_q;
  rsp_tag_t        tag1_q;
  logic [DW-1:0]   rd_data_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tag0_q    <= '0;
      tag1_q    <= '0;
      rd_data_q <= '0;
    end else begin
      tag0_q <= '{valid: hs, port: hs_port, is_read: hs & ~i_req_we[hs_port]};
      tag1_q <= tag0_q;
      if (tag0_q.valid && tag0_q.is_read) rd_data_q <= i_mem_data;
    end
  end

  assign o_rsp_valid = tag1_q.valid ? (tag1_q.port ? 2'b10 : 2'b01) : 2'b00;
  assign o_rsp_data  = tag1_q.is_read ? rd_data_q : '0;

endmodule

// File: tb/tb_data_bram_arbiter.sv
// Directed bench for data_bram_arbiter with a BRAM model, a transaction-level
// reference model and a per-cycle compare process.
module tb_data_bram_arbiter;
  import data_bram_pkg::*;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]           req_valid, req_ready, req_we, req_lock;
  logic [1:0][AW-1:0]   req_addr;
  logic [1:0][SW-1:0]   req_strb;
  logic [1:0][DW-1:0]   req_data;
  logic [1:0]           rsp_valid;
  logic [DW-1:0]        rsp_data;
  logic                 mem_rst, mem_rden, mem_wren;
  logic [AW-1:0]        mem_addr;
  logic [SW-1:0]        mem_strb;
  logic [DW-1:0]        mem_wdata;
  logic [DW-1:0]        bram_q;
  arb_state_e           dbg_state;

  data_bram_arbiter #(.AW(AW), .DW(DW)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_we    (req_we),
    .i_req_lock  (req_lock),
    .i_req_addr  (req_addr),
    .i_req_strb  (req_strb),
    .i_req_data  (req_data),
    .o_rsp_valid (rsp_valid),
    .o_rsp_data  (rsp_data),
    .o_mem_rst   (mem_rst),
    .o_mem_addr  (mem_addr),
    .o_mem_rden  (mem_rden),
    .o_mem_wren  (mem_wren),
    .o_mem_strb  (mem_strb),
    .o_mem_data  (mem_wdata),
    .i_mem_data  (bram_q),
    .o_dbg_state (dbg_state)
  );

  // ---------------- BRAM: reads on falling edge, writes on rising edge ----------------
  logic [DW-1:0] bram [1024];

  always @(negedge clk) if (mem_rden) bram_q <= bram[mem_addr];

  always @(posedge clk) begin
    if (mem_wren)
      for (int b = 0; b < SW; b++)
        if (mem_strb[b]) bram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  // ---------------- reference model ----------------
  int            cyc = 0;
  bit            m_locked = 1'b0;
  bit            m_lock_port = 1'b0;
  bit            m_last = 1'b1;
  int            rel_cnt = 0;
  logic [DW-1:0] m_mem [1024];
  logic [DW-1:0] exp_q[$];
  int            exp_port_q[$];
  int            exp_due_q[$];

  int            total = 0;
  int            bad = 0;
  int            gnt_log[$];
  int            rsp_port_log[$];
  logic [DW-1:0] rsp_data_log[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Which port the rules allow through right now.
  function automatic logic [1:0] model_grant();
    logic [1:0] g;
    int         winner;
    g = 2'b00;
    if (!rst_n || rel_cnt < 2) return g;
    if (m_locked) begin
      if (req_valid[m_lock_port]) g[m_lock_port] = 1'b1;
    end else if (req_valid != 2'b00) begin
      if (req_valid == 2'b11) winner = m_last ? 0 : 1;
      else                    winner = req_valid[0] ? 0 : 1;
      g[winner] = 1'b1;
    end
    return g;
  endfunction

  initial forever begin
    logic [1:0]    g;
    int            p;
    logic [DW-1:0] rd;
    @(posedge clk);
    g = model_grant();
    cyc++;
    if (!rst_n) begin
      m_locked = 1'b0;
      m_last   = 1'b1;
      rel_cnt  = 0;
      exp_q.delete();
      exp_port_q.delete();
      exp_due_q.delete();
    end else begin
      if (g != 2'b00) begin
        p  = g[1] ? 1 : 0;
        rd = req_we[p] ? '0 : m_mem[req_addr[p]];
        if (req_we[p])
          for (int b = 0; b < SW; b++)
            if (req_strb[p][b]) m_mem[req_addr[p]][8*b +: 8] = req_data[p][8*b +: 8];
        exp_q.push_back(rd);
        exp_port_q.push_back(p);
        exp_due_q.push_back(cyc + 1);
        m_last      = g[1];
        m_locked    = req_lock[p];
        m_lock_port = g[1];
      end
      if (rel_cnt < 2) rel_cnt++;
    end
  end

  // ---------------- scoreboard: compare every cycle on the falling edge ----------------
  initial forever begin
    logic [1:0]    ev;
    logic [DW-1:0] ed;
    logic [1:0]    eg;
    logic          emr;
    arb_state_e    es;
    @(negedge clk);
    ev = 2'b00;
    ed = '0;
    if (exp_due_q.size() != 0 && exp_due_q[0] == cyc) begin
      ev[exp_port_q[0]] = 1'b1;
      ed = exp_q[0];
      void'(exp_q.pop_front());
      void'(exp_port_q.pop_front());
      void'(exp_due_q.pop_front());
    end
    emr = !rst_n || rel_cnt < 2;
    eg  = model_grant();
    es  = (!rst_n || !m_locked) ? ARB : LOCKED;
    check("rsp_valid", 32'(rsp_valid), 32'(ev));
    if (ev != 2'b00) check("rsp_data", rsp_data, ed);
    check("req_ready", 32'(req_ready), 32'(eg));
    check("mem_rst", 32'(mem_rst), 32'(emr));
    check("fsm_state", 32'(dbg_state), 32'(es));
    if (req_ready[0] && req_valid[0]) gnt_log.push_back(0);
    if (req_ready[1] && req_valid[1]) gnt_log.push_back(1);
    if (rsp_valid != 2'b00) begin
      rsp_port_log.push_back(rsp_valid[1] ? 1 : 0);
      rsp_data_log.push_back(rsp_data);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int p, logic v, logic w, logic l, logic [AW-1:0] a,
                       logic [SW-1:0] s, logic [DW-1:0] d);
    req_valid[p] = v;
    req_we[p]    = w;
    req_lock[p]  = l;
    req_addr[p]  = a;
    req_strb[p]  = s;
    req_data[p]  = d;
  endtask

  task automatic idle();
    req_valid = 2'b00;
    req_lock  = 2'b00;
    req_we    = 2'b00;
  endtask

  task automatic clear_logs();
    gnt_log.delete();
    rsp_port_log.delete();
    rsp_data_log.delete();
  endtask

  task automatic check_rsp(string name, int idx, int port, logic [DW-1:0] data);
    check({name, "_present"}, 32'(rsp_data_log.size() > idx), 32'd1);
    if (rsp_data_log.size() > idx) begin
      check({name, "_port"}, rsp_port_log[idx], port);
      check({name, "_data"}, rsp_data_log[idx], data);
    end
  endtask

  task automatic check_gnts(string name, int n, int exp_gnt []);
    check({name, "_count"}, gnt_log.size(), n);
    for (int i = 0; i < n; i++)
      if (i < gnt_log.size()) check(name, gnt_log[i], exp_gnt[i]);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int g2 [];
    int g6 [];
    int g4 [];
    for (int i = 0; i < 1024; i++) begin
      bram[i]  = '0;
      m_mem[i] = '0;
    end
    bram_q    = '0;
    req_addr  = '0;
    req_strb  = '0;
    req_data  = '0;
    idle();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    // Reset held with both ports requesting.
    drive(0, 1, 0, 0, 10'h000, 4'h0, '0);
    drive(1, 1, 0, 0, 10'h001, 4'h0, '0);
    repeat (3) tick();
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_mem_rst", 32'(mem_rst), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    check("mem_rst_edge1", 32'(mem_rst), 32'd1);
    tick();
    clear_logs();
    @(negedge clk);
    check("mem_rst_edge2", 32'(mem_rst), 32'd0);
    check("first_ready", 32'(req_ready), 32'b01);
    tick();
    req_valid[0] = 1'b0;
    tick();
    idle();
    repeat (3) tick();
    g2 = '{0, 1};
    check_gnts("reset_gnt", 2, g2);

    // Write then read back on consecutive cycles.
    clear_logs();
    drive(0, 1, 1, 0, 10'h005, 4'hF, 32'hDEADBEEF);
    tick();
    drive(0, 1, 0, 0, 10'h005, 4'h0, '0);
    tick();
    idle();
    repeat (3) tick();
    check("wr_rd_count", rsp_data_log.size(), 2);
    check_rsp("wr_rsp", 0, 0, 32'h0);
    check_rsp("rd_rsp", 1, 0, 32'hDEADBEEF);

    // Partial-strobe write over an all-ones word.
    clear_logs();
    drive(0, 1, 1, 0, 10'h007, 4'hF, 32'hFFFFFFFF);
    tick();
    drive(0, 1, 1, 0, 10'h007, 4'b0101, 32'h11223344);
    tick();
    drive(0, 1, 0, 0, 10'h007, 4'h0, '0);
    tick();
    idle();
    repeat (3) tick();
    check_rsp("strb_rd", 2, 0, 32'hFF22FF44);

    // Point the round-robin at port 1, then contend for six cycles.
    drive(1, 1, 0, 0, 10'h007, 4'h0, '0);
    tick();
    idle();
    repeat (2) tick();
    clear_logs();
    drive(0, 1, 0, 0, 10'h005, 4'h0, '0);
    drive(1, 1, 0, 0, 10'h007, 4'h0, '0);
    repeat (6) tick();
    idle();
    repeat (3) tick();
    g6 = '{0, 1, 0, 1, 0, 1};
    check_gnts("rr_gnt", 6, g6);
    for (int i = 0; i < 6; i++)
      check_rsp("rr_rsp", i, i % 2, (i % 2 == 0) ? 32'hDEADBEEF : 32'hFF22FF44);

    // Lock held by port 1 while port 0 waits.
    drive(0, 1, 0, 0, 10'h005, 4'h0, '0);
    tick();
    idle();
    repeat (2) tick();
    clear_logs();
    drive(1, 1, 0, 1, 10'h010, 4'h0, '0);
    drive(0, 1, 0, 0, 10'h005, 4'h0, '0);
    @(negedge clk);
    check("lock_grant", 32'(req_ready), 32'b10);
    tick();
    req_valid[1] = 1'b0;
    req_lock[1]  = 1'b0;
    @(negedge clk);
    check("lock_hold", 32'(req_ready), 32'b00);
    check("lock_state", 32'(dbg_state), 32'(LOCKED));
    tick();
    drive(1, 1, 1, 0, 10'h010, 4'hF, 32'hCAFEF00D);
    @(negedge clk);
    check("unlock_grant", 32'(req_ready), 32'b10);
    tick();
    req_valid[1] = 1'b0;
    @(negedge clk);
    check("post_unlock", 32'(req_ready), 32'b01);
    tick();
    idle();
    repeat (2) tick();
    drive(1, 1, 0, 0, 10'h010, 4'h0, '0);
    tick();
    idle();
    repeat (3) tick();
    g4 = '{1, 1, 0, 1};
    check_gnts("lock_gnt", 4, g4);
    check_rsp("lock_rd", 2, 0, 32'hDEADBEEF);
    check_rsp("unlock_wr_rd", 3, 1, 32'hCAFEF00D);

    // Reset right after a locking read is accepted.
    drive(1, 1, 0, 1, 10'h010, 4'h0, '0);
    tick();
    rst_n = 1'b0;
    idle();
    clear_logs();
    repeat (3) tick();
    check("midflight_no_rsp", rsp_data_log.size(), 0);
    rst_n = 1'b1;
    drive(0, 1, 0, 0, 10'h005, 4'h0, '0);
    drive(1, 1, 0, 0, 10'h007, 4'h0, '0);
    repeat (2) tick();
    @(negedge clk);
    check("post_rst_state", 32'(dbg_state), 32'(ARB));
    check("post_rst_ready", 32'(req_ready), 32'b01);
    tick();
    idle();
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_bram_arbiter.md
# data_bram_arbiter

Two-requester arbiter and sequencer for the single-port data BRAM. Shares the BRAM between the core load/store unit (port 0) and the debug/DMA master (port 1) using valid/ready request handshakes and a fixed-latency response. Supports a per-port lock for atomic read-modify-write sequences. Sits between the requesters and the data BRAM, and drives the BRAM's command pins from registers.

## Interface
- AW, 10, word-address width, same as BRAM
- DW, 32, data width; SW = DW/8 byte strobes (derived, not overridable)
- i_clk  in  1  clock; the BRAM reads on its falling edge
- i_rst_n  in  1  asynchronous active-low reset
- i_req_valid  in  2  request valid, one bit per port
- o_req_ready  out  2  request accepted (grant), one bit per port
- i_req_we  in  2  1 = write, 0 = read
- i_req_lock  in  2  hold grant after this request (atomic sequence)
- i_req_addr  in  2×AW  word address per port
- i_req_strb  in  2×SW  byte strobes per port; ignored on reads
- i_req_data  in  2×DW  write data per port
- o_rsp_valid  out  2  response pulse; no backpressure
- o_rsp_data  out  DW  read data (shared); 0 for write responses
- o_mem_rst  out  1  active-high reset to BRAM
- o_mem_addr  out  AW  BRAM address
- o_mem_rden  out  1  BRAM read enable
- o_mem_wren  out  1  BRAM write enable
- o_mem_strb  out  SW  BRAM byte strobes
- o_mem_data  out  DW  BRAM write data
- i_mem_data  in  DW  BRAM read data

## Operation
- One grant per cycle max. o_req_ready is combinational from valid and arbiter state; a handshake is valid & ready at a rising edge.
- Arbitration in state ARB: round-robin. A last-grant pointer (reset 1, so port 0 wins first) flips to the winner on each handshake. With only one port valid, that port wins regardless of the pointer.
- Lock: a handshake with i_req_lock=1 moves the FSM to LOCKED(p). Only port p can be granted, and p has no arbitration delay. A port-p handshake with lock=0 returns the FSM to ARB, and that request is still performed. In LOCKED, the other port's ready is 0 even if p is idle.
- On a handshake, register o_mem_addr/strb/data, o_mem_rden = !we, and o_mem_wren = we. Without a handshake, rden and wren are 0; addr, strb and data hold their values.
- Response: every request produces exactly one o_rsp_valid pulse on the owning port. Reads return the captured i_mem_data; writes return 0.
- Response tracking: a 2-stage pipeline of {valid, port, is_read}.
- Reset values: o_req_ready 0, o_rsp_valid 0, o_rsp_data 0, all o_mem_* 0 except o_mem_rst 1, FSM = ARB, pointer = 1.
- o_mem_rst: asserts asynchronously with i_rst_n low. It deasserts at the 2nd rising edge after release (2-flop synchroniser). o_req_ready is forced 0 while o_mem_rst is 1.
- Reset mid-operation: in-flight responses are dropped (no o_rsp_valid) and a lock is released.

## Timing
- Handshake at edge t → BRAM command registered at t.
- BRAM samples addr/rden at the falling edge in cycle t..t+1; a write commits at edge t+1.
- Read data is captured into o_rsp_data at edge t+1. o_rsp_valid is high for exactly one cycle, t+1..t+2. Latency is 1 cycle from acceptance to response.
- Throughput is 1 request/cycle sustained, including back-to-back requests from alternating ports.
- Write at edge t followed by a read of the same address at edge t+1 returns the new data; no forwarding is needed.
- Simultaneous valid on both ports in ARB: the grant goes to the port that did not win last.
- Lock and unlock on the same port in consecutive cycles: the other port is eligible in the cycle after the unlocking handshake.

## Structure
- Shared package data_bram_pkg: enum arb_state_e {ARB, LOCKED}; typedef rsp_tag_t {valid, port, is_read}; constant NUM_PORTS = 2.
- One natural sub-module, rr_arbiter_2: a pure combinational grant from {valid, pointer, lock_en, lock_port}. FSM, pointer and pipeline stay in the top.
- Parameter checks: AW ≥ 1; DW a multiple of 8.

## Test plan
- Reset: hold i_rst_n low with both valid=1 → o_req_ready=0, o_mem_rst=1. After release, o_mem_rst falls at the 2nd edge, then the port-0 request is granted first.
- Write/read: port 0 writes 0xDEADBEEF to addr 0x005 with strb 0xF, then reads 0x005 in the next cycle → o_rsp_valid[0] pulses twice; the second response has o_rsp_data = 0xDEADBEEF, one cycle after acceptance.
- Byte strobes: write 0x11223344 with strb 0b0101 over 0xFFFFFFFF, then read → 0xFF22FF44.
- Round-robin: both ports valid with reads for 6 cycles → grants 0,1,0,1,0,1. Responses arrive in the same order with the correct port bits.
- Lock: port 1 locks a read of 0x010, port 0 stays valid; port 1 then writes 0x010 with lock=0 → port 0's ready stays 0 during the lock and it is granted in the cycle after the unlocking write.
- Reset mid-flight: assert i_rst_n low the cycle after a read handshake → no o_rsp_valid, FSM in ARB, lock cleared after release.
